// File: rtl/conv_scheduler.sv
// -----------------------------------------------------------------------------
// conv_scheduler
//   Sequences a convolution datapath (multiplier + accumulator) over a 24-bit
//   BMP pixel array. Loop order: channel -> row -> column -> kernel row ->
//   kernel column. Each multiply-accumulate step is issued as one tap (pixel
//   byte address, kernel word address, pad flag). The accumulator is cleared
//   once per output pixel, and each finished window is handed downstream
//   together with its coordinates.
//
// Ports
//   i_Clk, i_Reset          clock; synchronous active-high reset
//   i_Start                 one-cycle job request, honoured only when idle
//   i_ImageAddress          byte address of the first pixel-array byte
//   i_KernelAddress         byte address of kernel coefficient 0 (32-bit words)
//   i_ImageWidth/Height     image size W x H in pixels
//   i_KernelSize            kernel size K (odd, 1..MAX_K)
//   o_Busy, o_Done, o_Error job status; Error is sticky until the next Start
//   o_TapValid/i_TapReady   tap handshake; fields o_TapPixAddr, o_TapKerAddr,
//                           o_TapPad, o_TapLast
//   o_AccumReset            one-cycle accumulator clear before each window
//   i_AccumDone             accumulation of the last tap has completed
//   o_ResultValid/i_ResultReady  result handshake; fields o_ResultX,
//                           o_ResultY, o_ResultChan (0=B, 1=G, 2=R)
// -----------------------------------------------------------------------------
module conv_scheduler #(
  parameter int DIM_W  = 16,
  parameter int MAX_K  = 15,
  parameter int ADDR_W = 32
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Start,
  input  logic [ADDR_W-1:0] i_ImageAddress,
  input  logic [ADDR_W-1:0] i_KernelAddress,
  input  logic [DIM_W-1:0]  i_ImageWidth,
  input  logic [DIM_W-1:0]  i_ImageHeight,
  input  logic [DIM_W-1:0]  i_KernelSize,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Error,
  output logic              o_TapValid,
  input  logic              i_TapReady,
  output logic [ADDR_W-1:0] o_TapPixAddr,
  output logic [ADDR_W-1:0] o_TapKerAddr,
  output logic              o_TapPad,
  output logic              o_TapLast,
  output logic              o_AccumReset,
  input  logic              i_AccumDone,
  output logic              o_ResultValid,
  input  logic              i_ResultReady,
  output logic [DIM_W-1:0]  o_ResultX,
  output logic [DIM_W-1:0]  o_ResultY,
  output logic [1:0]        o_ResultChan
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_OUTPUT = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam int SW = DIM_W + 2;  // signed width for padded tap coordinates

  logic [2:0]        r_state, w_state_n;
  logic [ADDR_W-1:0] r_img_addr, r_ker_addr, r_stride;
  logic [DIM_W-1:0]  r_w, r_h, r_k, r_c;
  logic [DIM_W-1:0]  r_x, r_y, r_kx, r_ky, w_kx_n, w_ky_n;
  logic [1:0]        r_chan;

  logic              r_busy, r_done, r_error, r_accum_reset;
  logic              r_tap_valid, r_tap_pad, r_tap_last, r_result_valid;
  logic [ADDR_W-1:0] r_tap_pix, r_tap_ker;

  logic              w_bad_cfg, w_tap_hs, w_res_hs, w_job_last;
  logic signed [SW-1:0] w_px, w_py;
  logic              w_pad, w_last;
  logic [ADDR_W-1:0] w_pix, w_ker_off, w_ker;

  assign w_bad_cfg = (i_KernelSize == '0) || !i_KernelSize[0] ||
                     (i_KernelSize > DIM_W'(MAX_K)) ||
                     (i_ImageWidth == '0) || (i_ImageHeight == '0);

  assign w_tap_hs   = r_tap_valid & i_TapReady;
  assign w_res_hs   = r_result_valid & i_ResultReady;
  assign w_job_last = (r_chan == 2'd2) && (r_y == r_h - DIM_W'(1)) &&
                      (r_x == r_w - DIM_W'(1));

  always_comb begin
    // NOTE: every signal written here is defaulted first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_n = r_state;
    w_kx_n    = r_kx;
    w_ky_n    = r_ky;
    case (r_state)
      S_IDLE:  if (i_Start) w_state_n = S_SETUP;
      S_SETUP: w_state_n = w_bad_cfg ? S_ERR : S_CLEAR;
      S_CLEAR: begin
        w_kx_n    = '0;
        w_ky_n    = '0;
        w_state_n = S_ISSUE;
      end
      S_ISSUE: if (w_tap_hs) begin
        if (r_tap_last) begin
          w_state_n = S_DRAIN;
        end else if (r_kx == r_k - DIM_W'(1)) begin
          w_kx_n = '0;
          w_ky_n = r_ky + DIM_W'(1);
        end else begin
          w_kx_n = r_kx + DIM_W'(1);
        end
      end
      S_DRAIN:  if (i_AccumDone) w_state_n = S_OUTPUT;
      S_OUTPUT: if (w_res_hs) w_state_n = w_job_last ? S_FIN : S_CLEAR;
      S_FIN:    w_state_n = S_IDLE;
      S_ERR:    w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // Tap math is evaluated for the tap that will be presented next cycle, so
  // the registered tap fields can advance on every handshake.
  assign w_px = $signed({2'b00, r_x}) + $signed({2'b00, w_kx_n}) - $signed({2'b00, r_c});
  assign w_py = $signed({2'b00, r_y}) + $signed({2'b00, w_ky_n}) - $signed({2'b00, r_c});
  assign w_pad = (w_px < 0) || (w_px >= $signed({2'b00, r_w})) ||
                 (w_py < 0) || (w_py >= $signed({2'b00, r_h}));
  // Rows are stored bottom-up, so row py simply starts at py*Stride.
  assign w_pix = w_pad ? '0 :
                 r_img_addr + (ADDR_W'(w_py[DIM_W-1:0]) * r_stride) +
                 (ADDR_W'(w_px[DIM_W-1:0]) * ADDR_W'(3)) + ADDR_W'(r_chan);
  assign w_ker_off = (ADDR_W'(w_ky_n) * ADDR_W'(r_k)) + ADDR_W'(w_kx_n);
  assign w_ker     = r_ker_addr + (w_ker_off << 2);
  assign w_last    = (w_kx_n == r_k - DIM_W'(1)) && (w_ky_n == r_k - DIM_W'(1));

  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_Reset) begin
      r_state        <= S_IDLE;
      r_img_addr     <= '0;
      r_ker_addr     <= '0;
      r_stride       <= '0;
      r_w            <= '0;
      r_h            <= '0;
      r_k            <= '0;
      r_c            <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_kx           <= '0;
      r_ky           <= '0;
      r_chan         <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_accum_reset  <= 1'b0;
      r_tap_valid    <= 1'b0;
      r_tap_pad      <= 1'b0;
      r_tap_last     <= 1'b0;
      r_tap_pix      <= '0;
      r_tap_ker      <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_kx           <= w_kx_n;
      r_ky           <= w_ky_n;
      // Status and valid flags are registered from the next state so they
      // line up exactly with the state they describe.
      r_busy         <= (w_state_n != S_IDLE);
      r_done         <= (w_state_n == S_FIN) || (w_state_n == S_ERR);
      r_accum_reset  <= (w_state_n == S_CLEAR);
      r_tap_valid    <= (w_state_n == S_ISSUE);
      r_result_valid <= (w_state_n == S_OUTPUT);

      if (w_state_n == S_ERR)                r_error <= 1'b1;
      else if (r_state == S_IDLE && i_Start) r_error <= 1'b0;

      // While stalled the kernel indices hold, so these reload unchanged.
      if (w_state_n == S_ISSUE) begin
        r_tap_pix  <= w_pix;
        r_tap_ker  <= w_ker;
        r_tap_pad  <= w_pad;
        r_tap_last <= w_last;
      end

      if (r_state == S_SETUP) begin
        r_img_addr <= i_ImageAddress;
        r_ker_addr <= i_KernelAddress;
        r_w        <= i_ImageWidth;
        r_h        <= i_ImageHeight;
        r_k        <= i_KernelSize;
        r_c        <= (i_KernelSize - DIM_W'(1)) >> 1;
        // BMP rows are padded to a 4-byte multiple.
        r_stride   <= ((ADDR_W'(i_ImageWidth) * ADDR_W'(3)) + ADDR_W'(3)) & ~ADDR_W'(3);
        r_x        <= '0;
        r_y        <= '0;
        r_chan     <= '0;
      end

      if (r_state == S_OUTPUT && w_res_hs && !w_job_last) begin
        if (r_x == r_w - DIM_W'(1)) begin
          r_x <= '0;
          if (r_y == r_h - DIM_W'(1)) begin
            r_y    <= '0;
            r_chan <= r_chan + 2'd1;
          end else begin
            r_y <= r_y + DIM_W'(1);
          end
        end else begin
          r_x <= r_x + DIM_W'(1);
        end
      end
    end
  end

  assign o_Busy        = r_busy;
  assign o_Done        = r_done;
  assign o_Error       = r_error;
  assign o_TapValid    = r_tap_valid;
  assign o_TapPixAddr  = r_tap_pix;
  assign o_TapKerAddr  = r_tap_ker;
  assign o_TapPad      = r_tap_pad;
  assign o_TapLast     = r_tap_last;
  assign o_AccumReset  = r_accum_reset;
  assign o_ResultValid = r_result_valid;
  assign o_ResultX     = r_x;
  assign o_ResultY     = r_y;
  assign o_ResultChan  = r_chan;

endmodule

// File: tb/tb_conv_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_scheduler
//   Directed bench for conv_scheduler: a table of jobs with hand-computed
//   tap/result counts and Busy lengths, a table of hand-computed spot taps,
//   a reference tap/result sequence built from the loop nest, and hand-written
//   sequences for reset behaviour.
// -----------------------------------------------------------------------------
module tb_conv_scheduler;

  localparam logic [31:0] IMG = 32'h100;
  localparam logic [31:0] KER = 32'h400;

  logic        clk = 1'b0;
  logic        rst, start, tap_ready, accum_done, result_ready;
  logic [31:0] img_addr, ker_addr;
  logic [15:0] width, height, ksize;
  logic        busy, done, error, tap_valid, tap_pad, tap_last, accum_reset, result_valid;
  logic [31:0] tap_pix, tap_ker;
  logic [15:0] res_x, res_y;
  logic [1:0]  res_chan;

  always #5 clk = ~clk;

  conv_scheduler dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start),
    .i_ImageAddress(img_addr), .i_KernelAddress(ker_addr),
    .i_ImageWidth(width), .i_ImageHeight(height), .i_KernelSize(ksize),
    .o_Busy(busy), .o_Done(done), .o_Error(error),
    .o_TapValid(tap_valid), .i_TapReady(tap_ready),
    .o_TapPixAddr(tap_pix), .o_TapKerAddr(tap_ker),
    .o_TapPad(tap_pad), .o_TapLast(tap_last),
    .o_AccumReset(accum_reset), .i_AccumDone(accum_done),
    .o_ResultValid(result_valid), .i_ResultReady(result_ready),
    .o_ResultX(res_x), .o_ResultY(res_y), .o_ResultChan(res_chan)
  );

  typedef struct {
    int w, h, k;
    bit stall;
    int exp_taps, exp_res;
    bit exp_err;
    int exp_busy;   // 0 = not checked
  } job_t;

  typedef struct {
    int job, ch, x, y, kx, ky;
    bit pad, last;
    logic [31:0] pix, ker;
  } spot_t;

  typedef struct { logic [31:0] pix, ker; logic pad, last; } tap_t;
  typedef struct { int x, y, ch; } res_t;

  job_t  jobs[8];
  spot_t spots[12];
  tap_t  cap_taps[$], exp_taps[$];
  res_t  cap_res[$],  exp_res[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},   {31'd0, busy},         32'd0);
    check({tag, "_done"},   {31'd0, done},         32'd0);
    check({tag, "_error"},  {31'd0, error},        32'd0);
    check({tag, "_tapv"},   {31'd0, tap_valid},    32'd0);
    check({tag, "_taps"},   {tap_pad, tap_last, accum_reset, 29'd0}, 32'd0);
    check({tag, "_pix"},    tap_pix,               32'd0);
    check({tag, "_ker"},    tap_ker,               32'd0);
    check({tag, "_resv"},   {31'd0, result_valid}, 32'd0);
    check({tag, "_coord"},  {res_x, res_y[13:0], res_chan}, 32'd0);
  endtask

  // Reference sequence straight from the loop nest.
  task automatic build_model(input int wi, input int hi, input int ki);
    int c, stride, px, py;
    tap_t t;
    res_t r;
    exp_taps.delete();
    exp_res.delete();
    c      = (ki - 1) / 2;
    stride = ((3 * wi + 3) / 4) * 4;
    for (int ch = 0; ch < 3; ch++)
      for (int y = 0; y < hi; y++)
        for (int x = 0; x < wi; x++) begin
          for (int ky = 0; ky < ki; ky++)
            for (int kx = 0; kx < ki; kx++) begin
              px    = x + kx - c;
              py    = y + ky - c;
              t.pad = (px < 0) || (px >= wi) || (py < 0) || (py >= hi);
              t.pix = t.pad ? 32'd0 : IMG + 32'(py * stride + px * 3 + ch);
              t.ker = KER + 32'(4 * (ky * ki + kx));
              t.last = (kx == ki - 1) && (ky == ki - 1);
              exp_taps.push_back(t);
            end
          r.x = x; r.y = y; r.ch = ch;
          exp_res.push_back(r);
        end
  endtask

  task automatic run_job(input job_t j, input int idx);
    int   dcnt = 0, busy_cyc = 0, valid_cyc = 0, ar_cyc = 0, stab_err = 0, mism = 0, ti;
    bit   timed_out = 1'b1;
    logic prev_tstall = 1'b0, prev_rstall = 1'b0;
    tap_t t, prev_t;
    res_t r, prev_r;
    logic [8:0] pad_mask;
    string tag;
    tag = $sformatf("job%0d", idx);
    cap_taps.delete();
    cap_res.delete();
    if (j.exp_err) begin
      exp_taps.delete();
      exp_res.delete();
    end else begin
      build_model(j.w, j.h, j.k);
    end
    @(negedge clk);
    img_addr = IMG; ker_addr = KER;
    width = 16'(j.w); height = 16'(j.h); ksize = 16'(j.k);
    start = 1'b1; tap_ready = 1'b0; result_ready = 1'b0; accum_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start        = j.stall && (c == 20);  // stray Start while busy
      tap_ready    = j.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      result_ready = j.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      accum_done   = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) accum_done = 1'b1;
      end
      if (c == 0) check({tag, "_error_cleared"}, {31'd0, error}, 32'd0);
      if (busy)        busy_cyc++;
      if (tap_valid)   valid_cyc++;
      if (accum_reset) ar_cyc++;
      t.pix = tap_pix; t.ker = tap_ker; t.pad = tap_pad; t.last = tap_last;
      r.x = int'(res_x); r.y = int'(res_y); r.ch = int'(res_chan);
      if (prev_tstall && (!tap_valid || t != prev_t)) stab_err++;
      if (prev_rstall && (!result_valid || r != prev_r)) stab_err++;
      prev_tstall = tap_valid && !tap_ready;
      prev_rstall = result_valid && !result_ready;
      prev_t = t;
      prev_r = r;
      if (tap_valid && tap_ready) begin
        cap_taps.push_back(t);
        if (tap_last) dcnt = 2;
      end
      if (result_valid && result_ready) cap_res.push_back(r);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    check({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
    check({tag, "_error_at_done"}, {31'd0, error}, {31'd0, j.exp_err});
    @(negedge clk);
    check({tag, "_done_pulse"},   {30'd0, done, busy}, 32'd0);
    check({tag, "_error_sticky"}, {31'd0, error}, {31'd0, j.exp_err});
    check({tag, "_tap_count"}, 32'(cap_taps.size()), 32'(j.exp_taps));
    check({tag, "_res_count"}, 32'(cap_res.size()),  32'(j.exp_res));
    check({tag, "_accum_resets"}, 32'(ar_cyc), 32'(j.exp_res));
    check({tag, "_stable"}, 32'(stab_err), 32'd0);
    if (j.exp_busy > 0) check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(j.exp_busy));
    if (!j.stall) check({tag, "_throughput"}, 32'(valid_cyc), 32'(cap_taps.size()));
    for (int i = 0; i < cap_taps.size() && i < exp_taps.size(); i++)
      if (cap_taps[i] != exp_taps[i]) mism++;
    for (int i = 0; i < cap_res.size() && i < exp_res.size(); i++)
      if (cap_res[i] != exp_res[i]) mism++;
    check({tag, "_sequence"}, 32'(mism), 32'd0);
    foreach (spots[s]) begin
      if (spots[s].job != idx) continue;
      ti = ((spots[s].ch * j.h + spots[s].y) * j.w + spots[s].x) * j.k * j.k
           + spots[s].ky * j.k + spots[s].kx;
      if (ti >= cap_taps.size()) begin
        check($sformatf("%s_spot%0d_missing", tag, s), 32'(cap_taps.size()), 32'(ti + 1));
      end else begin
        check($sformatf("%s_spot%0d_pad", tag, s),  {31'd0, cap_taps[ti].pad},  {31'd0, spots[s].pad});
        check($sformatf("%s_spot%0d_last", tag, s), {31'd0, cap_taps[ti].last}, {31'd0, spots[s].last});
        check($sformatf("%s_spot%0d_pix", tag, s),  cap_taps[ti].pix, spots[s].pix);
        check($sformatf("%s_spot%0d_ker", tag, s),  cap_taps[ti].ker, spots[s].ker);
      end
    end
    if (idx == 0 && cap_taps.size() >= 9) begin
      pad_mask = 9'h04F;  // taps 0,1,2,3,6 of window (0,0) fall outside
      for (int i = 0; i < 9; i++)
        check($sformatf("%s_win0_pad%0d", tag, i), {31'd0, cap_taps[i].pad}, {31'd0, pad_mask[i]});
    end
  endtask

  initial begin
    int n_valid;
    bit seen;

    //        w  h  k  stall taps res err busy
    jobs[0] = '{2, 2, 3,  1'b0, 108, 12, 1'b0, 158};
    jobs[1] = '{3, 2, 3,  1'b0, 162, 18, 1'b0, 236};
    jobs[2] = '{3, 2, 3,  1'b1, 162, 18, 1'b0, 0};
    jobs[3] = '{2, 2, 4,  1'b0, 0,   0,  1'b1, 2};
    jobs[4] = '{2, 2, 0,  1'b0, 0,   0,  1'b1, 2};
    jobs[5] = '{1, 1, 1,  1'b0, 3,   3,  1'b0, 17};
    jobs[6] = '{0, 2, 3,  1'b0, 0,   0,  1'b1, 2};
    jobs[7] = '{2, 2, 17, 1'b0, 0,   0,  1'b1, 2};

    //          job ch x  y  kx ky pad   last  pix         ker
    spots[0]  = '{0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 32'h0,     32'h400};
    spots[1]  = '{0, 0, 0, 0, 1, 1, 1'b0, 1'b0, 32'h100,   32'h410};
    spots[2]  = '{0, 0, 0, 0, 2, 0, 1'b1, 1'b0, 32'h0,     32'h408};
    spots[3]  = '{0, 0, 0, 0, 0, 2, 1'b1, 1'b0, 32'h0,     32'h418};
    spots[4]  = '{0, 0, 0, 0, 2, 2, 1'b0, 1'b1, 32'h10B,   32'h420};
    spots[5]  = '{0, 1, 1, 1, 0, 0, 1'b0, 1'b0, 32'h101,   32'h400};
    spots[6]  = '{0, 2, 1, 0, 2, 1, 1'b1, 1'b0, 32'h0,     32'h414};
    spots[7]  = '{1, 2, 2, 1, 1, 1, 1'b0, 1'b0, 32'h114,   32'h410};
    spots[8]  = '{1, 0, 2, 0, 2, 1, 1'b1, 1'b0, 32'h0,     32'h414};
    spots[9]  = '{5, 0, 0, 0, 0, 0, 1'b0, 1'b1, 32'h100,   32'h400};
    spots[10] = '{5, 1, 0, 0, 0, 0, 1'b0, 1'b1, 32'h101,   32'h400};
    spots[11] = '{5, 2, 0, 0, 0, 0, 1'b0, 1'b1, 32'h102,   32'h400};

    rst = 1'b1; start = 1'b0; tap_ready = 1'b0; result_ready = 1'b0; accum_done = 1'b0;
    img_addr = '0; ker_addr = '0; width = '0; height = '0; ksize = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    for (int i = 0; i < 8; i++) run_job(jobs[i], i);

    // Reset in the middle of tap issue, together with a Start request.
    @(negedge clk);
    img_addr = IMG; ker_addr = KER; width = 16'd2; height = 16'd2; ksize = 16'd3;
    start = 1'b1; tap_ready = 1'b1; result_ready = 1'b1; accum_done = 1'b0;
    n_valid = 0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (tap_valid) n_valid++;
      if (n_valid == 4) begin
        seen = 1'b1;
        break;
      end
    end
    check("midjob_reached_issue", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_idle_zero("midjob_reset");
    @(negedge clk);
    check("reset_beats_start", {30'd0, busy, tap_valid}, 32'd0);

    run_job(jobs[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
